// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int RV_XLEN        = 32;
  localparam int STARVE_MAX_DEF = 2;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_I_REQ  = 3'd1,
    ARB_I_WAIT = 3'd2,
    ARB_D_REQ  = 3'd3,
    ARB_D_WAIT = 3'd4,
    ARB_RESP   = 3'd5
  } arb_state_t;

  typedef struct packed {
    logic                 we;
    logic [RV_XLEN/8-1:0] be;
    logic [RV_XLEN-1:0]   addr;
    logic [RV_XLEN-1:0]   wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-bus signals of the arbiter; master is the arbiter side.
interface mem_port_arbiter_if #(parameter int XLEN = 32);

  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_flush;
  logic [XLEN-1:0]   if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [XLEN/8-1:0] d_be;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN-1:0]   d_rdata;
  logic              d_done;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_rdata, d_done, d_stall,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_rdata, d_done, d_stall,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and load/store traffic onto one memory bus,
// one transaction outstanding, with fetch anti-starvation and redirect drop.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch command
// I_REQ  | fetch command on bus, waiting for mem_gnt
// I_WAIT | fetch accepted, waiting for mem_rvalid
// D_REQ  | data command on bus, waiting for mem_gnt
// D_WAIT | data accepted, waiting for mem_rvalid
// RESP   | one-cycle completion pulse to the owner
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN       = RV_XLEN,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [2:0] S_IDLE   = ARB_IDLE;
  localparam logic [2:0] S_I_REQ  = ARB_I_REQ;
  localparam logic [2:0] S_I_WAIT = ARB_I_WAIT;
  localparam logic [2:0] S_D_REQ  = ARB_D_REQ;
  localparam logic [2:0] S_D_WAIT = ARB_D_WAIT;
  localparam logic [2:0] S_RESP   = ARB_RESP;

  logic [2:0]      r_state;
  logic            r_drop;
  logic            r_resp_d;
  logic [SW-1:0]   r_starve;
  mem_cmd_t        r_cmd;
  logic [XLEN-1:0] r_if_rdata;
  logic [XLEN-1:0] r_d_rdata;

  logic w_pick_d;
  logic w_starved;
  logic w_resp;

  function automatic logic pick_data(input logic if_req, input logic d_req,
                                     input logic starved);
    return d_req & (~if_req | ~starved);
  endfunction

  assign w_starved = (r_starve == SW'(STARVE_MAX));
  assign w_pick_d  = pick_data(bus.if_req, bus.d_req, w_starved);
  assign w_resp    = (r_state == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_drop     <= 1'b0;
      r_resp_d   <= 1'b0;
      r_starve   <= '0;
      r_cmd      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.if_req) begin
            r_starve <= '0;
          end
          if (w_pick_d) begin
            r_state     <= S_D_REQ;
            r_resp_d    <= 1'b1;
            r_cmd.we    <= bus.d_we;
            r_cmd.be    <= bus.d_be;
            r_cmd.addr  <= bus.d_addr;
            r_cmd.wdata <= bus.d_wdata;
            if (bus.if_req && !w_starved) begin
              r_starve <= r_starve + SW'(1);
            end
          end else if (bus.if_req) begin
            // Fetches are always full-word reads.
            r_state     <= S_I_REQ;
            r_resp_d    <= 1'b0;
            r_cmd.we    <= 1'b0;
            r_cmd.be    <= '1;
            r_cmd.addr  <= bus.if_addr;
            r_cmd.wdata <= '0;
            r_starve    <= '0;
          end
        end
        S_I_REQ: begin
          if (bus.if_flush) r_drop <= 1'b1;
          if (bus.mem_gnt) r_state <= S_I_WAIT;
        end
        S_I_WAIT: begin
          if (bus.if_flush) r_drop <= 1'b1;
          if (bus.mem_rvalid) begin
            if (!(r_drop || bus.if_flush)) r_if_rdata <= bus.mem_rdata;
            r_state <= S_RESP;
          end
        end
        S_D_REQ: begin
          if (bus.mem_gnt) r_state <= S_D_WAIT;
        end
        S_D_WAIT: begin
          if (bus.mem_rvalid) begin
            r_d_rdata <= bus.mem_rdata;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          r_drop  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = (r_state == S_I_REQ) || (r_state == S_D_REQ);
  assign bus.mem_we    = r_cmd.we;
  assign bus.mem_be    = r_cmd.be;
  assign bus.mem_addr  = r_cmd.addr;
  assign bus.mem_wdata = r_cmd.wdata;

  assign bus.if_rdata = r_if_rdata;
  assign bus.if_valid = w_resp & ~r_resp_d & ~r_drop & ~bus.if_flush;
  assign bus.if_stall = bus.if_req & ~bus.if_valid;

  assign bus.d_rdata = r_d_rdata;
  assign bus.d_done  = w_resp & r_resp_d;
  assign bus.d_stall = bus.d_req & ~bus.d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of the memory-port arbiter: latency, priority/starvation,
// held grants, fetch drop on redirect, async reset and idle flush.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_pulse;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

  mem_port_arbiter #(.XLEN(32), .STARVE_MAX(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    // reset state
    step(); step();
    #1;
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_d_done", bus.d_done, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    rst = 1'b0;

    // single fetch, minimum latency
    for (int c = 0; c < 5; c++) begin
      step();
      case (c)
        0: begin bus.if_req = 1'b1; bus.if_addr = 32'h10; end
        1: bus.mem_gnt = 1'b1;
        2: begin bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h13; end
        3: bus.mem_rvalid = 1'b0;
        default: ;
      endcase
      #1;
      case (c)
        0: begin check("f1_stall_c0", bus.if_stall, 1'b1); check("f1_req_c0", bus.mem_req, 1'b0); end
        1: begin
          check("f1_req_c1", bus.mem_req, 1'b1);
          check("f1_addr", bus.mem_addr, 32'h10);
          check("f1_we", bus.mem_we, 1'b0);
          check("f1_stall_c1", bus.if_stall, 1'b1);
        end
        2: begin check("f1_req_c2", bus.mem_req, 1'b0); check("f1_stall_c2", bus.if_stall, 1'b1); end
        3: begin
          check("f1_valid", bus.if_valid, 1'b1);
          check("f1_rdata", bus.if_rdata, 32'h13);
          check("f1_stall_c3", bus.if_stall, 1'b0);
          bus.if_req = 1'b0;
        end
        4: begin check("f1_valid_off", bus.if_valid, 1'b0); check("f1_idle_req", bus.mem_req, 1'b0); end
        default: ;
      endcase
    end

    // simultaneous requests; data wins twice, then fetch is forced
    for (int c = 0; c < 13; c++) begin
      step();
      if (c == 0) begin
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h100;
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
      end
      bus.mem_rdata = 32'hA000_0000 + 32'(c);
      #1;
      case (c)
        1: begin check("pr_addr_d1", bus.mem_addr, 32'h100); check("pr_req_d1", bus.mem_req, 1'b1); end
        2: check("pr_dstall_c2", bus.d_stall, 1'b1);
        3: begin
          check("pr_done_1", bus.d_done, 1'b1);
          check("pr_rdata_1", bus.d_rdata, 32'hA000_0002);
          check("pr_ivalid_c3", bus.if_valid, 1'b0);
          check("pr_dstall_c3", bus.d_stall, 1'b0);
          check("pr_istall_c3", bus.if_stall, 1'b1);
        end
        4: check("pr_req_c4", bus.mem_req, 1'b0);
        5: check("pr_addr_d2", bus.mem_addr, 32'h100);
        7: begin check("pr_done_2", bus.d_done, 1'b1); check("pr_rdata_2", bus.d_rdata, 32'hA000_0006); end
        9: check("pr_addr_fetch", bus.mem_addr, 32'h20);
        11: begin
          check("pr_ivalid", bus.if_valid, 1'b1);
          check("pr_irdata", bus.if_rdata, 32'hA000_000A);
          check("pr_done_c11", bus.d_done, 1'b0);
          bus.if_req = 1'b0; bus.d_req = 1'b0;
          bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        end
        12: check("pr_idle", bus.mem_req, 1'b0);
        default: ;
      endcase
    end

    // store with grant delayed three cycles, stray rvalid while requesting
    n_pulse = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      case (c)
        0: begin
          bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
          bus.d_addr = 32'h200; bus.d_wdata = 32'hDEAD_BEEF;
        end
        2: bus.mem_rvalid = 1'b1;
        3: bus.mem_rvalid = 1'b0;
        4: bus.mem_gnt = 1'b1;
        5: begin bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678; end
        6: bus.mem_rvalid = 1'b0;
        default: ;
      endcase
      #1;
      if (bus.d_done) n_pulse++;
      if (c >= 1 && c <= 4) begin
        check($sformatf("st_req_c%0d", c), bus.mem_req, 1'b1);
        check($sformatf("st_addr_c%0d", c), bus.mem_addr, 32'h200);
        check($sformatf("st_wdata_c%0d", c), bus.mem_wdata, 32'hDEAD_BEEF);
        check($sformatf("st_be_c%0d", c), bus.mem_be, 32'h3);
        check($sformatf("st_we_c%0d", c), bus.mem_we, 1'b1);
      end
      case (c)
        5: check("st_req_wait", bus.mem_req, 1'b0);
        6: begin
          check("st_done", bus.d_done, 1'b1);
          check("st_dstall", bus.d_stall, 1'b0);
          bus.d_req = 1'b0;
        end
        7: check("st_done_off", bus.d_done, 1'b0);
        default: ;
      endcase
    end
    check("st_done_count", n_pulse, 1);

    // fetch redirected in I_WAIT is dropped; next fetch completes normally
    n_pulse = 0;
    for (int c = 0; c < 11; c++) begin
      step();
      case (c)
        0: begin bus.if_req = 1'b1; bus.if_addr = 32'h30; end
        1: bus.mem_gnt = 1'b1;
        2: begin bus.mem_gnt = 1'b0; bus.if_flush = 1'b1; bus.if_addr = 32'h40; end
        3: bus.if_flush = 1'b0;
        4: begin bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0; end
        5: bus.mem_rvalid = 1'b0;
        7: bus.mem_gnt = 1'b1;
        8: begin bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h4040_4040; end
        9: bus.mem_rvalid = 1'b0;
        default: ;
      endcase
      #1;
      if (c <= 8 && bus.if_valid) n_pulse++;
      case (c)
        1: check("fl_addr_old", bus.mem_addr, 32'h30);
        5: begin
          check("fl_no_valid", bus.if_valid, 1'b0);
          check("fl_rdata_kept", bus.if_rdata, 32'hA000_000A);
          check("fl_stall", bus.if_stall, 1'b1);
        end
        6: check("fl_idle", bus.mem_req, 1'b0);
        7: begin check("fl_req_new", bus.mem_req, 1'b1); check("fl_addr_new", bus.mem_addr, 32'h40); end
        9: begin
          check("fl_valid_new", bus.if_valid, 1'b1);
          check("fl_rdata_new", bus.if_rdata, 32'h4040_4040);
          bus.if_req = 1'b0;
        end
        10: check("fl_valid_off", bus.if_valid, 1'b0);
        default: ;
      endcase
    end
    check("fl_dropped_pulses", n_pulse, 0);

    // async reset in D_WAIT; later rvalid ignored
    n_pulse = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      case (c)
        0: begin
          bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF;
          bus.d_addr = 32'h300; bus.d_wdata = 32'h0;
        end
        1: bus.mem_gnt = 1'b1;
        2: bus.mem_gnt = 1'b0;
        3: rst = 1'b0;
        4: begin bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55; end
        5: bus.mem_rvalid = 1'b0;
        default: ;
      endcase
      #1;
      if (bus.d_done) n_pulse++;
      case (c)
        1: check("rs_addr", bus.mem_addr, 32'h300);
        2: begin
          check("rs_wait_req", bus.mem_req, 1'b0);
          #2 rst = 1'b1;
          bus.d_req = 1'b0;
          #1;
          check("rs_addr_clr", bus.mem_addr, 32'h0);
          check("rs_be_clr", bus.mem_be, 32'h0);
          check("rs_drdata_clr", bus.d_rdata, 32'h0);
          check("rs_irdata_clr", bus.if_rdata, 32'h0);
        end
        5: begin check("rs_no_done", bus.d_done, 1'b0); check("rs_drdata_kept", bus.d_rdata, 32'h0); end
        6: check("rs_req_idle", bus.mem_req, 1'b0);
        default: ;
      endcase
    end
    check("rs_done_count", n_pulse, 0);

    // flush while idle and in D_WAIT leaves the data transaction intact
    for (int c = 0; c < 5; c++) begin
      step();
      case (c)
        0: begin
          bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF;
          bus.d_addr = 32'h400; bus.if_flush = 1'b1;
        end
        1: begin bus.if_flush = 1'b0; bus.mem_gnt = 1'b1; end
        2: begin bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77; bus.if_flush = 1'b1; end
        3: begin bus.mem_rvalid = 1'b0; bus.if_flush = 1'b0; end
        default: ;
      endcase
      #1;
      case (c)
        1: begin check("if_req_d", bus.mem_req, 1'b1); check("if_addr_d", bus.mem_addr, 32'h400); end
        3: begin
          check("if_done", bus.d_done, 1'b1);
          check("if_drdata", bus.d_rdata, 32'h77);
          check("if_no_ivalid", bus.if_valid, 1'b0);
          bus.d_req = 1'b0;
        end
        4: check("if_done_off", bus.d_done, 1'b0);
        default: ;
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between the instruction fetch path and the MEM-stage load/store path.
- Serialises requests, with one transaction outstanding at a time.
- Drives per-requester stall signals into the hazard logic.
- Discards in-flight fetches when the fetch path is redirected by a branch, JAL or JALR.

Parameters:
- XLEN, 32 (riscv_pkg value): address and data width.
- STARVE_MAX, 2: maximum consecutive data grants while a fetch is waiting before fetch is forced to win.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  XLEN  fetch address (PC)
- if_flush  in  1  redirect; kill any pending fetch
- if_rdata  out  XLEN  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch-complete pulse
- if_stall  out  1  fetch path must hold
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store
- d_be  in  XLEN/8  byte enables
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_rdata  out  XLEN  load data, valid with d_done
- d_done  out  1  one-cycle data-complete pulse (loads and stores)
- d_stall  out  1  MEM path must hold
- mem_req  out  1  bus request, held until mem_gnt
- mem_we, mem_be, mem_addr, mem_wdata  out  1 / XLEN/8 / XLEN / XLEN  registered bus command
- mem_gnt  in  1  bus accepts command this cycle
- mem_rvalid  in  1  response valid; loads and stores both respond
- mem_rdata  in  XLEN  response data

Behaviour:
- States: IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT, RESP.
- Reset (async): state = IDLE; drop flag, starve count and all registered outputs = 0.
- IDLE arbitration:
  - Only d_req set: go to D_REQ.
  - Only if_req set: go to I_REQ.
  - Both set: data wins, unless starve count = STARVE_MAX, in which case fetch wins.
  - The command is latched into the mem_* registers on the transition.
- Starve count:
  - Increments on each data grant while if_req = 1.
  - Clears on any fetch grant, or whenever if_req = 0 in IDLE.
  - Saturates at STARVE_MAX.
- Request states:
  - In I_REQ and D_REQ, mem_req = 1 and the command is stable until mem_gnt.
  - On mem_gnt, go to I_WAIT or D_WAIT.
- Wait states:
  - In I_WAIT and D_WAIT, mem_req = 0.
  - On mem_rvalid, capture mem_rdata into if_rdata or d_rdata and go to RESP.
- RESP:
  - Lasts exactly one cycle, during which if_valid or d_done = 1; then go to IDLE.
  - Requests are sampled only in IDLE, so a request held through RESP does not duplicate.
- Minimum latency: request seen in IDLE at cycle 0; mem_req at 1; gnt at 1; rvalid at 2; done at 3.
- Flush:
  - if_flush in I_REQ or I_WAIT sets the drop flag.
  - The transaction still completes on the bus, because mem_req cannot be withdrawn before gnt.
  - In RESP with the drop flag set, if_valid = 0 and if_rdata is unchanged; the flag clears.
  - if_flush in IDLE, D_*, or on a fetch already in RESP has no effect on data transactions.
  - Flush in RESP suppresses that cycle's if_valid.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid.
  - d_stall = d_req & ~d_done.
- Stray mem_rvalid outside a wait state (including after a reset mid-transaction) is ignored.
- mem_gnt outside a request state is ignored.

Decomposition:
- riscv_pkg gains:
  - arb_state_t, enum of the six states.
  - mem_cmd_t, struct {we, be, addr, wdata}.
  - STARVE_MAX default constant.
- No sub-module; the priority choice is a local function.

Test Plan:
- Single fetch, if_req=1 at 0x0000_0010, gnt the same cycle, rvalid one cycle later with 0x0000_0013 -> mem_addr=0x10, if_valid pulse at cycle 3, if_rdata=0x13, if_stall high cycles 0-2.
- Simultaneous if_req and d_req (load 0x100) -> data first, d_done then if_valid. With d_req held continuously, fetch is granted after exactly STARVE_MAX=2 data grants.
- Store 0xDEADBEEF, be=0b0011, to 0x200 with gnt delayed 3 cycles -> mem_req and command stable for 4 cycles, single d_done, d_rdata unchanged-irrelevant.
- Fetch with if_flush in I_WAIT, rvalid later -> no if_valid pulse. The next fetch, to 0x40, completes normally with its own data.
- rst asserted asynchronously mid D_WAIT, then rvalid after release -> outputs 0 immediately, rvalid ignored, no d_done.
- Flush pulse while idle with d_req active -> data transaction unaffected, d_done asserted normally.
